// File: rtl/keccak_ipack.sv
// keccak_ipack -- byte-serial to word packer in front of a keccak core.
//
// Takes a message one byte at a time and packs it big-endian into
// BW_DATA-bit words: the first byte of each word goes in the MSB. A final
// partial word is zero-filled. There is one assembly register and one
// output register, so the next word can be assembled while the keccak side
// is still holding off the current one. The job parameters are latched at
// start for the core. The job ends when the core reports that squeezing is
// complete.
//
// Ports
//   i_clk, i_rstn         clock (rising edge), async active-low reset
//   i_start, i_abort      job request (IDLE only) / synchronous cancel
//   i_mode, i_ibytes_len, i_obytes_len   job parameters sampled at start
//   i_byte, i_byte_valid, o_byte_ready   byte-serial message input
//   o_ibytes, o_ibytes_valid, i_ibytes_ready   word stream to keccak
//   o_mode, o_ibytes_len, o_obytes_len   latched job parameters
//   i_obytes_done         keccak squeeze-complete pulse
//   o_busy, o_done, o_err job active / completion pulse / rejected start
module keccak_ipack #(
  parameter int BW_DATA  = 64,
  parameter int BW_IBLEN = 11,
  parameter int BW_OBLEN = 10
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [1:0]          i_mode,
  input  logic [BW_IBLEN-1:0] i_ibytes_len,
  input  logic [BW_OBLEN-1:0] i_obytes_len,
  input  logic [7:0]          i_byte,
  input  logic                i_byte_valid,
  output logic                o_byte_ready,
  output logic [BW_DATA-1:0]  o_ibytes,
  output logic                o_ibytes_valid,
  input  logic                i_ibytes_ready,
  output logic [1:0]          o_mode,
  output logic [BW_IBLEN-1:0] o_ibytes_len,
  output logic [BW_OBLEN-1:0] o_obytes_len,
  input  logic                i_obytes_done,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int NB     = BW_DATA / 8;
  localparam int BW_IDX = $clog2(NB);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_FILL      = 2'd1;
  localparam logic [1:0] S_DRAIN     = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]          state;
  logic [BW_DATA-1:0]  asm_reg;
  logic [BW_IDX-1:0]   asm_idx;
  logic                asm_full;
  logic [BW_DATA-1:0]  out_reg;
  logic                out_valid;
  logic [BW_IBLEN-1:0] byte_cnt;
  logic [BW_IBLEN-1:0] word_cnt;

  logic                byte_xfer;
  logic                word_xfer;
  logic                word_done;
  logic                out_free;
  logic [BW_DATA-1:0]  asm_next;
  logic [BW_IBLEN-1:0] start_words;

  // The byte counter reaching 0 closes off the source, so it can never
  // underflow.
  assign o_byte_ready = (state == S_FILL) && (byte_cnt != '0) && !asm_full;
  assign byte_xfer    = i_byte_valid && o_byte_ready;
  assign word_xfer    = out_valid && i_ibytes_ready;
  // The output register can take a word if it is empty or is emptying this
  // cycle. This is what gives back-to-back words with no bubble.
  assign out_free     = !out_valid || word_xfer;

  // A word is complete on its 8th byte or on the last byte of the message.
  // Unused low bytes stay zero because asm_reg is cleared for each new word.
  assign word_done = byte_xfer &&
                     ((asm_idx == BW_IDX'(NB - 1)) || (byte_cnt == BW_IBLEN'(1)));

  assign start_words = (i_ibytes_len >> BW_IDX) +
                       BW_IBLEN'(|i_ibytes_len[BW_IDX-1:0]);

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can
    // leave it unassigned and infer a latch.
    asm_next = asm_reg;
    asm_next = asm_reg | (BW_DATA'(i_byte) << (8 * (NB - 1 - int'(asm_idx))));
  end

  assign o_ibytes       = out_reg;
  assign o_ibytes_valid = out_valid;
  assign o_busy         = (state != S_IDLE);

  // NOTE: all state is written with non-blocking assignments, so every
  // register samples values from before the edge, whatever the statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= S_IDLE;
      asm_reg      <= '0;
      asm_idx      <= '0;
      asm_full     <= 1'b0;
      out_reg      <= '0;
      out_valid    <= 1'b0;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      o_mode       <= '0;
      o_ibytes_len <= '0;
      o_obytes_len <= '0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (i_abort && (state != S_IDLE)) begin
        // Cancel overrides every other action this cycle.
        state     <= S_IDLE;
        asm_reg   <= '0;
        asm_idx   <= '0;
        asm_full  <= 1'b0;
        out_reg   <= '0;
        out_valid <= 1'b0;
        byte_cnt  <= '0;
        word_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              if (i_ibytes_len != '0) begin
                o_mode       <= i_mode;
                o_ibytes_len <= i_ibytes_len;
                o_obytes_len <= i_obytes_len;
                byte_cnt     <= i_ibytes_len;
                word_cnt     <= start_words;
                state        <= S_FILL;
              end else begin
                o_err <= 1'b1;
              end
            end
          end
          S_FILL: begin
            if (byte_xfer && (byte_cnt == BW_IBLEN'(1))) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (word_xfer && (word_cnt == BW_IBLEN'(1))) state <= S_WAIT_DONE;
          end
          default: begin
            if (i_obytes_done) begin
              o_done <= 1'b1;
              state  <= S_IDLE;
            end
          end
        endcase

        if (byte_xfer) byte_cnt <= byte_cnt - BW_IBLEN'(1);
        if (word_xfer && (word_cnt != '0)) word_cnt <= word_cnt - BW_IBLEN'(1);

        if (word_done) begin
          asm_idx <= '0;
          if (out_free) begin
            out_reg   <= asm_next;
            out_valid <= 1'b1;
            asm_reg   <= '0;
          end else begin
            // The output is still held off, so park the word in assembly.
            asm_reg  <= asm_next;
            asm_full <= 1'b1;
          end
        end else begin
          if (byte_xfer) begin
            asm_reg <= asm_next;
            asm_idx <= asm_idx + BW_IDX'(1);
          end
          if (asm_full && out_free) begin
            out_reg   <= asm_reg;
            out_valid <= 1'b1;
            asm_reg   <= '0;
            asm_full  <= 1'b0;
          end else if (word_xfer) begin
            out_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keccak_ipack.sv
// Directed testbench for keccak_ipack: reset, packing, backpressure, error,
// abort and mid-job reset, with hand-computed expected words.
module tb_keccak_ipack;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [1:0]  i_mode = '0;
  logic [10:0] i_ibytes_len = '0;
  logic [9:0]  i_obytes_len = '0;
  logic [7:0]  i_byte = '0;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready;
  logic [63:0] o_ibytes;
  logic        o_ibytes_valid;
  logic        i_ibytes_ready = 1'b1;
  logic [1:0]  o_mode;
  logic [10:0] o_ibytes_len;
  logic [9:0]  o_obytes_len;
  logic        i_obytes_done = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  keccak_ipack dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_mode         (i_mode),
    .i_ibytes_len   (i_ibytes_len),
    .i_obytes_len   (i_obytes_len),
    .i_byte         (i_byte),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .o_ibytes       (o_ibytes),
    .o_ibytes_valid (o_ibytes_valid),
    .i_ibytes_ready (i_ibytes_ready),
    .o_mode         (o_mode),
    .o_ibytes_len   (o_ibytes_len),
    .o_obytes_len   (o_obytes_len),
    .i_obytes_done  (i_obytes_done),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] words[$];

  // Record every accepted output word.
  always @(posedge i_clk) begin
    if (o_ibytes_valid && i_ibytes_ready) words.push_back(o_ibytes);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic start_job(input logic [1:0] m, input logic [10:0] il, input logic [9:0] ol);
    i_start = 1'b1; i_mode = m; i_ibytes_len = il; i_obytes_len = ol;
    cyc(1);
    i_start = 1'b0;
  endtask

  // Sends n bytes (first, first+1, ...). Returns at the negedge just after
  // the posedge that transferred the last byte.
  task automatic send_bytes(input logic [7:0] first, input int n);
    int sent = 0;
    int budget = 0;
    while (sent < n && budget < 300) begin
      if (o_byte_ready) begin
        i_byte_valid = 1'b1;
        i_byte = 8'(int'(first) + sent);
        sent++;
      end else begin
        i_byte_valid = 1'b0;
      end
      cyc(1);
      budget++;
    end
    i_byte_valid = 1'b0;
    if (sent < n) check("send_timeout", 64'(sent), 64'(n));
  endtask

  task automatic finish_job(input string tag);
    i_obytes_done = 1'b1;
    cyc(1);
    i_obytes_done = 1'b0;
    check({tag, "_done"}, 64'(o_done), 64'd1);
    check({tag, "_idle"}, 64'(o_busy), 64'd0);
    cyc(1);
    check({tag, "_done_pulse"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    // Reset values.
    cyc(2);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_valid", 64'(o_ibytes_valid), 64'd0);
    check("rst_ready", 64'(o_byte_ready), 64'd0);
    check("rst_data", o_ibytes, 64'd0);
    check("rst_err_done", 64'({o_err, o_done}), 64'd0);
    check("rst_params", 64'({o_mode, o_ibytes_len, o_obytes_len}), 64'd0);
    i_rstn = 1'b1;
    cyc(1);

    // len=8: a single full word.
    words.delete();
    start_job(2'd2, 11'd8, 10'd32);
    check("j8_busy", 64'(o_busy), 64'd1);
    check("j8_mode", 64'(o_mode), 64'd2);
    check("j8_ilen", 64'(o_ibytes_len), 64'd8);
    check("j8_olen", 64'(o_obytes_len), 64'd32);
    check("j8_ready", 64'(o_byte_ready), 64'd1);
    send_bytes(8'h01, 8);
    check("j8_valid", 64'(o_ibytes_valid), 64'd1);
    check("j8_word", o_ibytes, 64'h0102030405060708);
    cyc(1);
    check("j8_valid_drop", 64'(o_ibytes_valid), 64'd0);
    check("j8_count", 64'(words.size()), 64'd1);
    check("j8_wait_busy", 64'(o_busy), 64'd1);
    finish_job("j8");

    // len=13 with a start attempt while busy.
    words.delete();
    start_job(2'd1, 11'd13, 10'd16);
    i_start = 1'b1; i_ibytes_len = 11'd0;
    cyc(1);
    i_start = 1'b0;
    check("busy_start_err", 64'(o_err), 64'd0);
    check("busy_start_len", 64'(o_ibytes_len), 64'd13);
    send_bytes(8'h01, 13);
    cyc(3);
    check("j13_count", 64'(words.size()), 64'd2);
    if (words.size() >= 2) begin
      check("j13_w0", words[0], 64'h0102030405060708);
      check("j13_w1", words[1], 64'h090A0B0C0D000000);
    end
    finish_job("j13");

    // len=24 with output backpressure.
    words.delete();
    i_ibytes_ready = 1'b0;
    start_job(2'd0, 11'd24, 10'd64);
    send_bytes(8'h01, 16);
    check("bp_ready_low", 64'(o_byte_ready), 64'd0);
    check("bp_valid", 64'(o_ibytes_valid), 64'd1);
    check("bp_w0_hold", o_ibytes, 64'h0102030405060708);
    cyc(20);
    check("bp_w0_stable", o_ibytes, 64'h0102030405060708);
    check("bp_ready_still_low", 64'(o_byte_ready), 64'd0);
    check("bp_no_xfer", 64'(words.size()), 64'd0);
    i_ibytes_ready = 1'b1;
    send_bytes(8'h11, 8);
    cyc(3);
    check("bp_count", 64'(words.size()), 64'd3);
    if (words.size() >= 3) begin
      check("bp_w0", words[0], 64'h0102030405060708);
      check("bp_w1", words[1], 64'h090A0B0C0D0E0F10);
      check("bp_w2", words[2], 64'h1112131415161718);
    end
    finish_job("bp");

    // Zero-length start is rejected.
    i_start = 1'b1; i_ibytes_len = 11'd0;
    cyc(1);
    i_start = 1'b0;
    check("err_pulse", 64'(o_err), 64'd1);
    check("err_busy", 64'(o_busy), 64'd0);
    cyc(1);
    check("err_one_cycle", 64'(o_err), 64'd0);
    check("err_still_idle", 64'(o_busy), 64'd0);

    // Abort after 5 of 16 bytes, then a clean job.
    words.delete();
    start_job(2'd3, 11'd16, 10'd8);
    send_bytes(8'h01, 5);
    i_abort = 1'b1;
    cyc(1);
    i_abort = 1'b0;
    check("ab_busy", 64'(o_busy), 64'd0);
    check("ab_ready", 64'(o_byte_ready), 64'd0);
    check("ab_valid", 64'(o_ibytes_valid), 64'd0);
    i_obytes_done = 1'b1;
    cyc(1);
    i_obytes_done = 1'b0;
    check("ab_done_ignored", 64'(o_done), 64'd0);
    cyc(3);
    check("ab_no_words", 64'(words.size()), 64'd0);
    start_job(2'd0, 11'd8, 10'd8);
    send_bytes(8'h21, 8);
    check("ab_fresh_word", o_ibytes, 64'h2122232425262728);
    check("ab_fresh_valid", 64'(o_ibytes_valid), 64'd1);
    cyc(1);
    finish_job("ab_fresh");

    // Reset mid-FILL acts immediately.
    start_job(2'd2, 11'd16, 10'd100);
    send_bytes(8'h01, 3);
    #2 i_rstn = 1'b0;
    #1;
    check("mr_busy", 64'(o_busy), 64'd0);
    check("mr_ready", 64'(o_byte_ready), 64'd0);
    check("mr_valid_data", 64'(o_ibytes_valid) | o_ibytes, 64'd0);
    check("mr_params", 64'({o_mode, o_ibytes_len, o_obytes_len}), 64'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    cyc(1);
    start_job(2'd1, 11'd8, 10'd8);
    check("mr_restart_busy", 64'(o_busy), 64'd1);
    check("mr_restart_mode", 64'(o_mode), 64'd1);
    i_abort = 1'b1;
    cyc(1);
    i_abort = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keccak_ipack.md
KECCAK_IPACK -- requirements
Module: keccak_ipack

Interface
REQ-001 Parameters (name, default, meaning): BW_DATA, 64, keccak input word width; BW_IBLEN, 11, input byte-length width (max 1184 B); BW_OBLEN, 10, output byte-length width (max 784 B).
REQ-002 i_clk  in  1  clock; all state on rising edge.
REQ-003 i_rstn  in  1  reset, asynchronous, active-low.
REQ-004 i_start  in  1  one-cycle job request; sampled only in IDLE.
REQ-005 i_abort  in  1  synchronous job cancel.
REQ-006 i_mode  in  2  keccak mode for the job.
REQ-007 i_ibytes_len  in  BW_IBLEN  message length in bytes.
REQ-008 i_obytes_len  in  BW_OBLEN  requested output length in bytes.
REQ-009 i_byte / i_byte_valid / o_byte_ready  in 8 / in 1 / out 1  byte-serial message source, first byte first.
REQ-010 o_ibytes / o_ibytes_valid / i_ibytes_ready  out BW_DATA / out 1 / in 1  word stream to keccak.
REQ-011 o_mode, o_ibytes_len, o_obytes_len  out 2 / BW_IBLEN / BW_OBLEN  job parameters latched at start, held until IDLE.
REQ-012 i_obytes_done  in  1  keccak squeeze-complete pulse.
REQ-013 o_busy, o_done, o_err  out 1 each  job active; one-cycle completion pulse; one-cycle rejected-start pulse.

Function
REQ-014 FSM states IDLE, FILL, DRAIN, WAIT_DONE; o_busy=1 in every state except IDLE.
REQ-015 IDLE: i_start with i_ibytes_len!=0 latches mode/lengths, loads byte counter with i_ibytes_len, word counter with ceil(len/8), goes to FILL.
REQ-016 IDLE: i_start with i_ibytes_len==0 pulses o_err next cycle; state stays IDLE.
REQ-017 Byte transfer occurs on i_byte_valid && o_byte_ready; o_byte_ready=1 only in FILL while bytes remain and the assembly register is not full.
REQ-018 Packing: k-th byte of a word (k=0..7) occupies o_ibytes[63-8k -: 8]; first message byte lands in MSB of word 0.
REQ-019 Final partial word (len mod 8 != 0) is zero-filled in unused low bytes; it is complete after its last real byte.
REQ-020 Double buffering: completed assembly word moves to output register when output is empty or handshakes that same cycle; assembly of the next word proceeds while output waits.
REQ-021 o_ibytes_valid rises the cycle after the completing byte transfer (registered); o_ibytes and o_ibytes_valid hold stable until i_ibytes_ready.
REQ-022 Peak throughput: one word per 8 byte cycles, no bubble from output backpressure unless both registers are full.
REQ-023 FILL -> DRAIN when byte counter reaches 0; DRAIN -> WAIT_DONE on handshake of the last word (word counter reaches 0).
REQ-024 WAIT_DONE: i_obytes_done pulses o_done next cycle, state -> IDLE; i_obytes_done in any other state ignored.
REQ-025 i_start while o_busy=1 ignored, no o_err.
REQ-026 i_abort in any non-IDLE state: next cycle IDLE, valid/ready deasserted, counters and buffers cleared, no o_done; i_abort has priority over i_start and handshakes the same cycle.
REQ-027 Byte and word counters never wrap: decrement only on transfer, saturate at 0.

Reset
REQ-028 i_rstn low asynchronously forces IDLE; o_ibytes=0, o_ibytes_valid=0, o_byte_ready=0, o_busy=0, o_done=0, o_err=0, o_mode=0, o_ibytes_len=0, o_obytes_len=0, buffers cleared.
REQ-029 Reset mid-job discards the job; first legal start is the first rising edge after i_rstn deasserts.

Verification
REQ-030 len=8, bytes 0x01..0x08, ready=1 -> one word 0x0102030405060708, valid one cycle after 8th byte, then WAIT_DONE.
REQ-031 len=13, bytes 0x01..0x0D -> words 0x0102030405060708, 0x090A0B0C0D000000; exactly 2 valid handshakes.
REQ-032 len=24, i_ibytes_ready low 20 cycles -> word 0 stable, word 1 assembled, o_byte_ready low until ready returns; 3 words in order.
REQ-033 i_start with len=0 -> o_err pulse 1 cycle, o_busy stays 0; i_start during a busy job -> ignored.
REQ-034 i_abort after 5 of 16 bytes -> IDLE next cycle, no further valid, no o_done; fresh len=8 job then completes correctly.
REQ-035 i_obytes_done in WAIT_DONE -> o_done 1-cycle pulse, o_busy 0; i_rstn low mid-FILL -> all outputs at reset values immediately.
